stencil_column_sequencer: RTL and testbench

Control block in front of `stencil_core_2d`. It loads the weight vector, streams `COLUMNS` input columns from a column memory into the core one per cycle, and collects the `TILES` results the core emits. It sits between the host-side start/config interface and the core's `io_in_*` / `io_out_*` ports.

---
 rtl/stencil_column_sequencer.sv | 149 ++++++++++++++
 tb/tb_stencil_column_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stencil_column_sequencer.sv
// Column sequencer in front of stencil_core_2d: loads weights, streams COLUMNS columns, collects TILES results.
// Optional drain watchdog enabled by defining STENCIL_SEQ_TIMEOUT_EN.
module stencil_column_sequencer #(
  parameter int BW            = 32,
  parameter int ST            = 5,
  parameter int COLUMNS       = 10,
  parameter int TILES         = 2,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int IW = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             cfg_weight_we,
  input  logic [BW*ST-1:0] cfg_weight,
  output logic             col_rd_en,
  output logic [CW-1:0]    col_rd_addr,
  input  logic [BW*ST-1:0] col_rd_data,
  output logic             core_in_ready,
  output logic [BW*ST-1:0] core_in_matrix,
  output logic [BW*ST-1:0] core_in_weight,
  input  logic             core_out_valid,
  input  logic [BW-1:0]    core_out_data,
  output logic             res_valid,
  output logic [BW-1:0]    res_data,
  output logic [IW-1:0]    res_index,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for start, weights writable
  // STREAM | issuing one column read per non-held cycle
  // DRAIN  | all columns issued, waiting for remaining results
  // DONE   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam int TW = $clog2(TILES + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     col_cnt_q;
  logic [TW-1:0]     tile_cnt_q;
  logic              rd_pend_q;
  logic [BW*ST-1:0]  matrix_q;
  logic [BW*ST-1:0]  weight_q;
  logic              res_valid_q;
  logic [BW-1:0]     res_data_q;
  logic [IW-1:0]     res_index_q;
  logic              accept;

`ifdef STENCIL_SEQ_TIMEOUT_EN
  localparam int TOW = $clog2(DRAIN_TIMEOUT + 1);
  logic [TOW-1:0]    to_q;
  logic              timeout;
  logic              err_q;
`endif

  always_comb begin
    state_d   = state_q;
    col_rd_en = 1'b0;
    accept    = core_out_valid && (state_q == STREAM || state_q == DRAIN)
                && (tile_cnt_q < TW'(TILES));
`ifdef STENCIL_SEQ_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: if (!hold) begin
                col_rd_en = 1'b1;
                if (col_cnt_q == CW'(COLUMNS - 1)) state_d = DRAIN;
              end
      DRAIN: begin
        if (tile_cnt_q == TW'(TILES)) state_d = DONE;
`ifdef STENCIL_SEQ_TIMEOUT_EN
        else if (!accept && to_q == TOW'(DRAIN_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      matrix_q    <= '0;
      weight_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= col_rd_en;
      if (rd_pend_q) matrix_q <= col_rd_data;
      if (state_q == IDLE && cfg_weight_we) weight_q <= cfg_weight;
      if (state_q == IDLE && start) begin
        col_cnt_q  <= '0;
        tile_cnt_q <= '0;
      end else begin
        if (col_rd_en) col_cnt_q <= col_cnt_q + 1'b1;
        if (accept) tile_cnt_q <= tile_cnt_q + 1'b1;
      end
      res_valid_q <= accept;
      if (accept) begin
        res_data_q  <= core_out_data;
        res_index_q <= tile_cnt_q[IW-1:0];
      end
    end
  end

`ifdef STENCIL_SEQ_TIMEOUT_EN
  // Idle cycles since the last accepted result, only counted while draining
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == DRAIN) to_q <= accept ? '0 : to_q + 1'b1;
      else to_q <= '0;
      if (state_q == IDLE && start) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Read data is only valid for one cycle, so the matrix bus bypasses it and then holds it
  assign core_in_matrix = rd_pend_q ? col_rd_data : matrix_q;
  assign core_in_ready  = rd_pend_q;
  assign core_in_weight = weight_q;
  assign col_rd_addr    = col_cnt_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_index      = res_index_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

endmodule

// File: tb/tb_stencil_column_sequencer.sv
// Self-checking bench for stencil_column_sequencer: random columns/holds/results against a schedule model.
// Timeout checks are compiled in when STENCIL_SEQ_TIMEOUT_EN is defined.
module tb_stencil_column_sequencer;
  localparam int BW = 32, ST = 5, COLUMNS = 10, TILES = 2, W = BW * ST;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0, cfg_weight_we = 1'b0;
  logic [W-1:0]  cfg_weight = '0, col_rd_data = '0;
  logic          col_rd_en, core_in_ready, core_out_valid = 1'b0;
  logic [3:0]    col_rd_addr;
  logic [W-1:0]  core_in_matrix, core_in_weight;
  logic [BW-1:0] core_out_data = '0, res_data;
  logic [0:0]    res_index;
  logic          res_valid, busy, done, err;

  int passed = 0, total = 0;
  logic [W-1:0] wcur = '0, lastm = '0;
  logic [W-1:0] mem [COLUMNS];

  stencil_column_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .cfg_weight_we(cfg_weight_we), .cfg_weight(cfg_weight),
    .col_rd_en(col_rd_en), .col_rd_addr(col_rd_addr), .col_rd_data(col_rd_data),
    .core_in_ready(core_in_ready), .core_in_matrix(core_in_matrix), .core_in_weight(core_in_weight),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .busy(busy), .done(done), .err(err));

  always #5 clock = ~clock;

  // Column memory: one-cycle read latency
  always @(posedge clock) if (col_rd_en) col_rd_data <= mem[col_rd_addr];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_w(input logic [W-1:0] v);
    @(negedge clock);
    cfg_weight_we = 1'b1;
    cfg_weight    = v;
    @(negedge clock);
    cfg_weight_we = 1'b0;
    wcur = v;
    #1 chk("weight_load", core_in_weight, wcur);
  endtask

  // mode 0: no hold, 1: hold 3 cycles after column 4, 2: random hold.
  // nres: results the core returns (3 = one extra after the run is full). poke: mid-run start/weight write.
  task automatic run(input int mode, input int nres, input bit poke);
    bit h[256];
    int iss[COLUMNS];
    int rc0, rc1, rc2, done_k, last, a, n;
    logic [BW-1:0] d0, d1, d2;
    logic err_exp;
    for (int j = 0; j < COLUMNS; j++) mem[j] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 256; k++)
      h[k] = (mode == 1) ? (k >= 5 && k <= 7) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    // column j is issued on the (j+1)-th cycle without hold
    n = 0;
    for (int k = 0; k < 256; k++) if (!h[k] && n < COLUMNS) begin iss[n] = k; n++; end
    a = iss[COLUMNS-1];
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    if (nres >= 2) begin
      rc0 = $urandom_range(1, 8);
      rc1 = rc0 + $urandom_range(1, 14);
      done_k = ((rc1 > a) ? rc1 : a) + 2;
    end else begin
      rc0 = a + 3;
      rc1 = -100;
      done_k = rc0 + 65;
    end
    rc2 = (nres == 3) ? rc1 + $urandom_range(1, 8) : -100;
    last = ((rc2 > done_k) ? rc2 : done_k) + 2;
    err_exp = 1'b0;

    @(negedge clock);
    start = 1'b1; hold = 1'b0; core_out_valid = 1'b0;
    for (int k = 0; k <= last; k++) begin
      int pj, ij;
      @(negedge clock);
      start          = poke && (k == 3);
      cfg_weight_we  = poke && (k == 3);
      cfg_weight     = ~wcur;
      hold           = h[k];
      core_out_valid = (k == rc0) || (k == rc1) || (k == rc2);
      core_out_data  = (k == rc0) ? d0 : (k == rc1) ? d1 : (k == rc2) ? d2 : $urandom;
      #1;
      pj = -1; ij = -1;
      for (int j = 0; j < COLUMNS; j++) begin
        if (iss[j] + 1 == k) pj = j;
        if (iss[j] == k) ij = j;
      end
      chk("core_in_ready", W'(core_in_ready), W'(pj >= 0));
      if (pj >= 0) lastm = mem[pj];
      chk("core_in_matrix", core_in_matrix, lastm);
      chk("col_rd_en", W'(col_rd_en), W'(ij >= 0));
      if (ij >= 0) chk("col_rd_addr", W'(col_rd_addr), W'(ij));
      chk("core_in_weight", core_in_weight, wcur);
      chk("busy", W'(busy), W'(k <= done_k));
      chk("done", W'(done), W'(k == done_k));
      chk("res_valid", W'(res_valid), W'((k == rc0 + 1) || (nres >= 2 && k == rc1 + 1)));
      if (k == rc0 + 1) begin
        chk("res_data0", W'(res_data), W'(d0));
        chk("res_index0", W'(res_index), W'(0));
      end
      if (nres >= 2 && k == rc1 + 1) begin
        chk("res_data1", W'(res_data), W'(d1));
        chk("res_index1", W'(res_index), W'(1));
      end
`ifdef STENCIL_SEQ_TIMEOUT_EN
      if (nres == 1 && k >= done_k) err_exp = 1'b1;
`endif
      chk("err", W'(err), W'(err_exp));
    end
    start = 1'b0; cfg_weight_we = 1'b0; hold = 1'b0; core_out_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_col_rd_en", W'(col_rd_en), '0);
    chk("rst_col_rd_addr", W'(col_rd_addr), '0);
    chk("rst_core_in_ready", W'(core_in_ready), '0);
    chk("rst_core_in_matrix", core_in_matrix, '0);
    chk("rst_core_in_weight", core_in_weight, '0);
    chk("rst_res_valid", W'(res_valid), '0);
    chk("rst_res_data", W'(res_data), '0);
    chk("rst_res_index", W'(res_index), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    reset = 1'b1;

    load_w({5{32'h3F800000}});
    run(0, 2, 1'b0);
    run(1, 2, 1'b0);
    load_w({$urandom, $urandom, $urandom, $urandom, $urandom});
    run(2, 3, 1'b1);

    // Reset while column 6 is being presented
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clock);
    #1 chk("pre_reset_ready", W'(core_in_ready), W'(1));
    reset = 1'b0;
    #1;
    chk("midrst_ready", W'(core_in_ready), '0);
    chk("midrst_rd_en", W'(col_rd_en), '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_weight", core_in_weight, '0);
    @(negedge clock);
    reset = 1'b1;
    wcur = '0;
    lastm = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("postrst_ready", W'(core_in_ready), '0);
      chk("postrst_rd_en", W'(col_rd_en), '0);
    end

    load_w({$urandom, $urandom, $urandom, $urandom, $urandom});
    run(0, 2, 1'b0);
    for (int r = 0; r < 4; r++) run(2, 2 + (r % 2), r[0]);
`ifdef STENCIL_SEQ_TIMEOUT_EN
    run(0, 1, 1'b0);
    run(2, 2, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
